// File: rtl/fetch_unit.sv
// Instruction fetch: requests 32-bit words at the PC and presents them as two 16-bit Thumb halves.
// Latency: accept edge -> instr_valid_out the next cycle; reset release -> request on the first edge.
// Backpressure: the request is held until an accept, and the half on instr_out is held while decoder_stall_in is high.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  fetch_load_out,
    output logic [ADDR_WIDTH-1:0] fetch_addr_out,
    input  logic                  stall_mem2fetch_in,
    input  logic                  mem_output_valid_in,
    input  logic [31:0]           mem_data_in,
    input  logic                  branch_valid_in,
    input  logic [ADDR_WIDTH-1:0] branch_target_in,
    input  logic                  decoder_stall_in,
    output logic [15:0]           instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc_out,
    output logic                  instr_valid_out
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = {RESET_PC[ADDR_WIDTH-1:1], 1'b0};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]             word_q, word_d;
    logic                    run_q;
    logic                    accept;

    // run_q keeps the request low until the first edge after reset release.
    assign fetch_load_out = run_q && (state_q == ST_REQ || state_q == ST_DISCARD);
    assign fetch_addr_out = {pc_q[ADDR_WIDTH-1:2], 2'b00};
    assign accept         = fetch_load_out && mem_output_valid_in && !stall_mem2fetch_in;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        if (branch_valid_in) begin
            pc_d = branch_target_in & ~ADDR_WIDTH'(1);
            // A request still in flight owes us exactly one stale word.
            if (fetch_load_out && !accept) begin
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (accept) begin
                        word_d  = mem_data_in;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!decoder_stall_in) begin
                        pc_d = pc_q + ADDR_WIDTH'(2);
                        if (pc_q[1]) begin
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (accept) begin
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_comb begin
        instr_valid_out = 1'b0;
        instr_out       = '0;
        instr_pc_out    = '0;
        if (state_q == ST_HOLD) begin
            instr_valid_out = 1'b1;
            instr_out       = pc_q[1] ? word_q[31:16] : word_q[15:0];
            instr_pc_out    = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_REQ;
            pc_q    <= PC_INIT;
            word_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle plus literal spot checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_load_out;
    logic [15:0] fetch_addr_out;
    logic        stall_mem2fetch_in;
    logic        mem_output_valid_in;
    logic [31:0] mem_data_in;
    logic        branch_valid_in;
    logic [15:0] branch_target_in;
    logic        decoder_stall_in;
    logic [15:0] instr_out;
    logic [15:0] instr_pc_out;
    logic        instr_valid_out;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_load_out      (fetch_load_out),
        .fetch_addr_out      (fetch_addr_out),
        .stall_mem2fetch_in  (stall_mem2fetch_in),
        .mem_output_valid_in (mem_output_valid_in),
        .mem_data_in         (mem_data_in),
        .branch_valid_in     (branch_valid_in),
        .branch_target_in    (branch_target_in),
        .decoder_stall_in    (decoder_stall_in),
        .instr_out           (instr_out),
        .instr_pc_out        (instr_pc_out),
        .instr_valid_out     (instr_valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: m_live = out of reset for an edge, m_have = a fetched word is held,
    // m_owed = a stale word is still due from before a redirect.
    logic        m_live, m_have, m_owed;
    logic [15:0] m_pc;
    logic [31:0] m_word;
    logic        m_load, m_got;

    always_comb begin
        m_load = m_live && !m_have;
        m_got  = m_load && mem_output_valid_in && !stall_mem2fetch_in;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_live <= 1'b0;
            m_have <= 1'b0;
            m_owed <= 1'b0;
            m_pc   <= 16'h0000;
            m_word <= 32'h0;
        end else begin
            m_live <= 1'b1;
            if (branch_valid_in) begin
                m_pc   <= {branch_target_in[15:1], 1'b0};
                m_have <= 1'b0;
                m_owed <= m_load && !m_got;
            end else if (m_got) begin
                if (m_owed) begin
                    m_owed <= 1'b0;
                end else begin
                    m_word <= mem_data_in;
                    m_have <= 1'b1;
                end
            end else if (m_have && !decoder_stall_in) begin
                m_pc <= m_pc + 16'd2;
                if (m_pc[1]) m_have <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("load", {31'b0, fetch_load_out}, {31'b0, m_load});
            chk("addr", {16'b0, fetch_addr_out}, {16'b0, m_pc[15:2], 2'b00});
            chk("valid", {31'b0, instr_valid_out}, {31'b0, m_have});
            chk("instr", {16'b0, instr_out},
                m_have ? {16'b0, (m_pc[1] ? m_word[31:16] : m_word[15:0])} : 32'h0);
            chk("ipc", {16'b0, instr_pc_out}, m_have ? {16'b0, m_pc} : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic spot(input string tag, input logic ld, input logic [15:0] addr,
                        input logic vld, input logic [15:0] ins, input logic [15:0] ipc);
        chk({tag, ".load"}, {31'b0, fetch_load_out}, {31'b0, ld});
        chk({tag, ".addr"}, {16'b0, fetch_addr_out}, {16'b0, addr});
        chk({tag, ".valid"}, {31'b0, instr_valid_out}, {31'b0, vld});
        chk({tag, ".instr"}, {16'b0, instr_out}, {16'b0, ins});
        chk({tag, ".ipc"}, {16'b0, instr_pc_out}, {16'b0, ipc});
    endtask

    task automatic give(input logic [31:0] w);
        mem_output_valid_in = 1'b1;
        mem_data_in         = w;
        tick();
        mem_output_valid_in = 1'b0;
        mem_data_in         = 32'h0;
    endtask

    initial begin
        reset               = 1'b0;
        stall_mem2fetch_in  = 1'b0;
        mem_output_valid_in = 1'b0;
        mem_data_in         = 32'h0;
        branch_valid_in     = 1'b0;
        branch_target_in    = 16'h0;
        decoder_stall_in    = 1'b0;

        // 1: reset held three cycles, then request at 0 on the first edge
        tick();
        cmp_on = 1'b1;
        tick();
        tick();
        spot("rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        #1;
        chk("rel.load_before_edge", {31'b0, fetch_load_out}, 32'h0);
        tick();
        spot("rel", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        // 2: both halves streamed out, then next word requested
        give(32'h4321_1234);
        spot("t2a", 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0000);
        tick();
        spot("t2b", 1'b0, 16'h0000, 1'b1, 16'h4321, 16'h0002);
        tick();
        spot("t2c", 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000);

        // 3: decoder stall holds the lower half stable
        decoder_stall_in = 1'b1;
        give(32'h4321_1234);
        spot("t3a", 1'b0, 16'h0004, 1'b1, 16'h1234, 16'h0004);
        tick();
        tick();
        spot("t3b", 1'b0, 16'h0004, 1'b1, 16'h1234, 16'h0004);
        decoder_stall_in = 1'b0;
        tick();
        spot("t3c", 1'b0, 16'h0004, 1'b1, 16'h4321, 16'h0006);
        tick();
        spot("t3d", 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000);

        // 4: data while the controller serves the decoder is not ours
        stall_mem2fetch_in = 1'b1;
        give(32'hDEAD_BEEF);
        stall_mem2fetch_in = 1'b0;
        spot("t4a", 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000);
        tick();
        give(32'h5678_9ABC);
        spot("t4b", 1'b0, 16'h0008, 1'b1, 16'h9ABC, 16'h0008);
        tick();
        tick();
        spot("t4c", 1'b1, 16'h000C, 1'b0, 16'h0000, 16'h0000);

        // 5: branch with a request outstanding drops exactly one word
        branch_valid_in  = 1'b1;
        branch_target_in = 16'h0106;
        tick();
        branch_valid_in  = 1'b0;
        spot("t5a", 1'b1, 16'h0104, 1'b0, 16'h0000, 16'h0000);
        give(32'hAAAA_BBBB);
        spot("t5b", 1'b1, 16'h0104, 1'b0, 16'h0000, 16'h0000);
        give(32'hCCCC_DDDD);
        spot("t5c", 1'b0, 16'h0104, 1'b1, 16'hCCCC, 16'h0106);
        tick();
        spot("t5d", 1'b1, 16'h0108, 1'b0, 16'h0000, 16'h0000);

        // branch coinciding with an accept drops that word
        branch_valid_in  = 1'b1;
        branch_target_in = 16'h0200;
        give(32'h1111_2222);
        branch_valid_in  = 1'b0;
        spot("bacc", 1'b1, 16'h0200, 1'b0, 16'h0000, 16'h0000);

        // branch during HOLD, then PC wrap from 0xFFFE
        give(32'h3333_4444);
        spot("hold", 1'b0, 16'h0200, 1'b1, 16'h4444, 16'h0200);
        branch_valid_in  = 1'b1;
        branch_target_in = 16'hFFFF;
        tick();
        branch_valid_in  = 1'b0;
        spot("bhold", 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0000);
        give(32'hBEEF_0000);
        spot("wrap_a", 1'b0, 16'hFFFC, 1'b1, 16'hBEEF, 16'hFFFE);
        tick();
        spot("wrap_b", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

        // 6: reset mid-request, data during reset ignored
        branch_valid_in  = 1'b1;
        branch_target_in = 16'h0040;
        tick();
        branch_valid_in  = 1'b0;
        reset = 1'b0;
        #1;
        spot("t6a", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        mem_output_valid_in = 1'b1;
        mem_data_in         = 32'h1111_2222;
        tick();
        tick();
        spot("t6b", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        mem_output_valid_in = 1'b0;
        mem_data_in         = 32'h0;
        reset = 1'b1;
        tick();
        spot("t6c", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        tick();
        spot("t6d", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        give(32'h9999_8888);
        spot("t6e", 1'b0, 16'h0000, 1'b1, 16'h8888, 16'h0000);
        tick();

        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
